// File: rtl/line_mem_arbiter_pkg.sv
// Shared types and defaults for the line memory arbiter.
// Build option: ARB_PERF_CNT_EN enables per-channel grant/wait counters.
package rv32i_types;

  localparam int ARB_NUM_CH = 2;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_mem_arbiter_if.sv
// Requester-side and memory-side bus of the line memory arbiter.
// master: arbiter view; slave: requesters plus physical memory.
interface line_mem_arbiter_if
  import rv32i_types::*;
#(
  parameter int NUM_CH = ARB_NUM_CH,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
);

  logic [NUM_CH-1:0]             ch_read;
  logic [NUM_CH-1:0]             ch_write;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]             ch_rdata;
  logic [NUM_CH-1:0]             ch_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  ch_read, ch_write,
    input  ch_addr, ch_wdata,
    output ch_rdata, ch_resp,
    output mem_read, mem_write,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output ch_read, ch_write,
    output ch_addr, ch_wdata,
    input  ch_rdata, ch_resp,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/line_mem_arbiter_rr_picker.sv
// Find-first requesting channel at or after the round-robin pointer.
// Search wraps modulo NUM_CH.
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IW     = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic              valid_o,
  output logic [IW-1:0]     idx_o
);

  always_comb begin
    int j;
    j       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter of NUM_CH line requesters onto one burst port.
// Build option: ARB_PERF_CNT_EN adds grant_cnt/wait_cnt outputs.
module line_mem_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_CH = ARB_NUM_CH,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic clk,
  input  logic rst,
  line_mem_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [NUM_CH-1:0][31:0] grant_cnt,
  output logic [NUM_CH-1:0][31:0] wait_cnt
`endif
);

  localparam int IW = idx_w(NUM_CH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic [NUM_CH-1:0] req;
  logic              pick_v;
  logic [IW-1:0]     pick_idx;

  assign req = bus.ch_read | bus.ch_write;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_v),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (pick_v) begin
          state_d = S_ISSUE;
          idx_d   = pick_idx;
          addr_d  = bus.ch_addr[pick_idx];
          wdata_d = bus.ch_wdata[pick_idx];
          // Read+write on one channel is illegal; write wins.
          wr_d    = bus.ch_write[pick_idx];
          rd_d    = ~bus.ch_write[pick_idx];
        end
      end
      (state_q == S_ISSUE): begin
        if (bus.mem_resp) begin
          state_d = S_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) rdata_d = bus.mem_rdata;
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        ptr_d   = (idx_q == IW'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ch_rdata  = rdata_q;
  assign bus.ch_resp   = (state_q == S_DONE) ?
                         (NUM_CH'(1) << idx_q) : '0;

`ifdef ARB_PERF_CNT_EN
  logic [NUM_CH-1:0][31:0] gcnt_q, wcnt_q;
  logic [NUM_CH-1:0]       g_inc, w_inc;

  always_comb begin
    g_inc = '0;
    w_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == S_IDLE) begin
        g_inc[i] = pick_v && (pick_idx == IW'(i));
        w_inc[i] = req[i] && !g_inc[i];
      end else begin
        w_inc[i] = req[i] && (idx_q != IW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (g_inc[i] && (gcnt_q[i] != '1))
          gcnt_q[i] <= gcnt_q[i] + 32'd1;
        if (w_inc[i] && (wcnt_q[i] != '1))
          wcnt_q[i] <= wcnt_q[i] + 32'd1;
      end
    end
  end

  assign grant_cnt = gcnt_q;
  assign wait_cnt  = wcnt_q;
`endif

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Parametrised round-robin arbiter that multiplexes NUM_CH cache-line requesters (I-cache, D-cache, future prefetcher/victim buffer) onto the single physical burst memory port of the mp4 core. It replaces the fixed point-to-point wiring of the data port to physical memory. It latches one line transaction at a time, holds the memory handshake stable, and returns a one-cycle response to the granted channel.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (>=1)
- ADDR_W, 32, line address width
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ch_read  in  NUM_CH  per-channel line read request, held until own ch_resp
- ch_write  in  NUM_CH  per-channel line write request, held until own ch_resp
- ch_addr  in  NUM_CH x ADDR_W  per-channel line address
- ch_wdata  in  NUM_CH x LINE_W  per-channel write line
- ch_rdata  out  LINE_W  registered read line, broadcast; valid only with own ch_resp
- ch_resp  out  NUM_CH  one-hot, one-cycle completion pulse
- mem_read  out  1  physical memory read
- mem_write  out  1  physical memory write
- mem_addr  out  ADDR_W  physical address (registered)
- mem_wdata  out  LINE_W  physical write line (registered)
- mem_rdata  in  LINE_W  physical read line
- mem_resp  in  1  physical completion, one cycle
- grant_cnt  out  NUM_CH x 32  grants per channel (ARB_PERF_CNT_EN only)
- wait_cnt  out  NUM_CH x 32  stalled-request cycles per channel (ARB_PERF_CNT_EN only)

## Operation
- Reset values: all outputs 0, state IDLE, rr pointer 0, latched channel 0, counters 0.
- States: IDLE, ISSUE, DONE.
- IDLE: if any ch_read|ch_write, pick first requesting channel at or after rr pointer (modulo NUM_CH); latch index, addr, wdata, op; go ISSUE. No requests: stay IDLE.
- ISSUE: mem_read/mem_write driven from latched op, mem_addr/mem_wdata from latched regs, all stable. On mem_resp: capture mem_rdata into ch_rdata if read, drop mem_read/mem_write, go DONE.
- DONE: ch_resp[latched]=1 for exactly this cycle; rr pointer <= latched+1, wrapping NUM_CH-1 -> 0; go IDLE.
- ch_read and ch_write both high on one channel: illegal; write wins.
- Requester dropping its request mid-ISSUE: ignored; transaction completes, ch_resp still pulses.
- Non-granted channels' inputs ignored outside IDLE; changes to granted channel's addr/wdata after latch ignored.
- NUM_CH=1: pointer stays 0; index width is max(1, $clog2(NUM_CH)).
- Reset asserted mid-ISSUE: immediate return to IDLE, memory strobes drop asynchronously, transaction abandoned, no ch_resp.

## Timing
- Request seen in IDLE at cycle 0 -> mem_read/mem_write high from cycle 1.
- mem_resp in cycle k -> mem strobes low in k+1, ch_resp and ch_rdata valid in k+1.
- Next arbitration in cycle k+2 (IDLE); pending channel's strobe high in k+3.
- Minimum turnaround: 3 cycles overhead per transaction plus memory latency.
- mem_resp outside ISSUE ignored.

## Configuration
- ARB_PERF_CNT_EN defined: grant_cnt/wait_cnt ports and logic present. grant_cnt[i] increments on entering ISSUE for channel i; wait_cnt[i] increments each cycle channel i requests and is not the latched channel in ISSUE/DONE, or loses in IDLE. Both saturate at 32'hFFFF_FFFF; reset to 0.
- Not defined: ports and counter logic absent; arbitration behaviour identical.

## Structure
- arb_state_t enum {IDLE, ISSUE, DONE} and default NUM_CH/LINE_W constants belong in rv32i_types.
- One sub-module: rr_picker, combinational find-first-set rotated by pointer; outputs valid flag and index.
- Arbiter FSM, latches and counters live in line_mem_arbiter.

## Test plan
- Reset with ch_read=2'b11 held: all outputs 0 during reset; after release, ch0 granted first, mem_addr=ch_addr[0].
- ch0 read addr 0x0000_0100, mem_resp 3 cycles after strobe with rdata 0xA5 pattern -> ch_resp=2'b01 one cycle later, ch_rdata=0xA5 pattern, mem_read low that cycle.
- Both channels requesting continuously, NUM_CH=2 -> grants alternate 0,1,0,1 over 4 transactions.
- NUM_CH=3, ch2 write addr 0x0000_0040 wdata 0xDEAD.., ch1 read both high -> with pointer=2, ch2 granted, mem_write=1, mem_wdata=0xDEAD..; then ch1; pointer wraps to 0.
- Reset pulsed mid-ISSUE -> mem_read drops same cycle, no ch_resp, next grant restarts at ch0.
- ARB_PERF_CNT_EN, ch0 and ch1 each requesting once simultaneously, memory latency 2 -> grant_cnt={1,1}, wait_cnt[1]=5, wait_cnt[0]=0.
